lc3_datapath_p: RTL and testbench

LC3_DATAPATH_P -- requirements
Module: lc3_datapath_p

---
 rtl/lc3_pkg.sv | 47 ++++
 rtl/lc3_mem_ctrl.sv | 81 ++++++++
 rtl/lc3_datapath_p.sv | 165 ++++++++++++++++
 tb/tb_lc3_datapath_p.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 datapath: control mux codes, memory FSM states
// and bit positions inside the GATE and LD control vectors.
package lc3_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_NOT  = 2'd2,
        ALU_PASS = 2'd3
    } aluk_e;

    typedef enum logic [1:0] {
        PC_BUS   = 2'd0,
        PC_ADDER = 2'd1,
        PC_INC   = 2'd2,
        PC_HOLD  = 2'd3
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_OFF11 = 2'd0,
        A2_OFF9  = 2'd1,
        A2_OFF6  = 2'd2,
        A2_ZERO  = 2'd3
    } addr2mux_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int GATE_MDR    = 3;
    localparam int GATE_PC     = 2;
    localparam int GATE_MARMUX = 1;
    localparam int GATE_ALU    = 0;

    localparam int LD_MAR = 6;
    localparam int LD_MDR = 5;
    localparam int LD_IR  = 4;
    localparam int LD_PC  = 3;
    localparam int LD_BEN = 2;
    localparam int LD_CC  = 1;
    localparam int LD_REG = 0;

    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3_mem_ctrl.sv
// Memory handshake controller: IDLE -> REQ -> DONE with a bounded wait for ACK.
// A read completion is flagged to the datapath so MDR can capture the read data.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic we,
    input  logic ack,
    output logic req,
    output logic busy,
    output logic done,
    output logic timeout,
    output logic rd_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state;
    mem_state_e       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             we_q;
    logic             timeout_q;
    logic             expire;

    // ACK on the last allowed cycle wins over the timeout.
    assign expire = (state == ST_REQ) && !ack && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ: begin
                if (ack) begin
                    state_nxt = ST_DONE;
                end else if (expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (state == ST_IDLE && start) begin
                wait_cnt <= '0;
                we_q     <= we;
            end else if (state == ST_REQ && !ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req     = (state == ST_REQ);
        busy    = (state == ST_REQ);
        done    = (state == ST_DONE);
        timeout = timeout_q;
        rd_done = (state == ST_REQ) && ack && !we_q;
    end

endmodule

// File: rtl/lc3_datapath_p.sv
// LC-3 datapath: shared bus, register file, ALU, address adder, PC/MAR/MDR/IR,
// condition codes and branch enable, with a timed memory handshake.
module lc3_datapath_p
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       GATE,
    input  logic [6:0]       LD,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       ALUK,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             MEM_START,
    input  logic             MEM_WE,
    input  logic             MEM_ACK,
    input  logic [WIDTH-1:0] MEM_RDATA,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] BUS,
    output logic             MEM_REQ,
    output logic [WIDTH-1:0] MEM_ADDR,
    output logic [WIDTH-1:0] MEM_WDATA,
    output logic             MEM_BUSY,
    output logic             MEM_DONE,
    output logic             MEM_TIMEOUT,
    output logic             BEN,
    output logic             BUS_CONFLICT,
    output logic [2:0]       NZP
);

    logic [WIDTH-1:0] regs [8];
    logic [2:0]       dr;
    logic [2:0]       sr1;
    logic [WIDTH-1:0] sr1_val;
    logic [WIDTH-1:0] sr2_val;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] addr2;
    logic [WIDTH-1:0] adder_out;
    logic             rd_done;

    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return 3'b100;
        end else if (v == '0) begin
            return 3'b010;
        end
        return 3'b001;
    endfunction

    lc3_mem_ctrl #(.TIMEOUT(TIMEOUT)) u_mem_ctrl (
        .clk     (Clk),
        .rst_n   (Reset),
        .start   (MEM_START),
        .we      (MEM_WE),
        .ack     (MEM_ACK),
        .req     (MEM_REQ),
        .busy    (MEM_BUSY),
        .done    (MEM_DONE),
        .timeout (MEM_TIMEOUT),
        .rd_done (rd_done)
    );

    assign MEM_ADDR  = MAR;
    assign MEM_WDATA = MDR;

    assign dr      = DRMUX ? 3'd7 : IR[11:9];
    assign sr1     = SR1MUX ? IR[8:6] : IR[11:9];
    assign sr1_val = regs[sr1];
    assign sr2_val = SR2MUX ? WIDTH'($signed(IR[4:0])) : regs[IR[2:0]];

    always_comb begin
        alu_out = '0;
        case (aluk_e'(ALUK))
            ALU_ADD:  alu_out = sr1_val + sr2_val;
            ALU_AND:  alu_out = sr1_val & sr2_val;
            ALU_NOT:  alu_out = ~sr1_val;
            ALU_PASS: alu_out = sr1_val;
            default:  alu_out = '0;
        endcase
    end

    assign addr1 = ADDR1MUX ? PC : sr1_val;

    always_comb begin
        addr2 = '0;
        case (addr2mux_e'(ADDR2MUX))
            A2_OFF11: addr2 = WIDTH'($signed(IR[10:0]));
            A2_OFF9:  addr2 = WIDTH'($signed(IR[8:0]));
            A2_OFF6:  addr2 = WIDTH'($signed(IR[5:0]));
            A2_ZERO:  addr2 = '0;
            default:  addr2 = '0;
        endcase
    end

    assign adder_out = addr1 + addr2;

    // Two or more drivers is a control error: the bus is forced to zero.
    always_comb begin
        BUS_CONFLICT = |(GATE & (GATE - 4'd1));
        BUS          = '0;
        if (!BUS_CONFLICT) begin
            if (GATE[GATE_MDR]) begin
                BUS = MDR;
            end else if (GATE[GATE_PC]) begin
                BUS = PC;
            end else if (GATE[GATE_MARMUX]) begin
                BUS = adder_out;
            end else if (GATE[GATE_ALU]) begin
                BUS = alu_out;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (LD[LD_REG]) begin
            regs[dr] <= BUS;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            MAR <= '0;
            MDR <= '0;
            IR  <= '0;
            PC  <= '0;
            NZP <= NZP_RESET;
            BEN <= 1'b0;
        end else begin
            if (LD[LD_MAR]) MAR <= BUS;
            if (rd_done) begin
                MDR <= MEM_RDATA;
            end else if (LD[LD_MDR]) begin
                MDR <= BUS;
            end
            if (LD[LD_IR]) IR <= BUS;
            if (LD[LD_PC]) begin
                case (pcmux_e'(PCMUX))
                    PC_BUS:   PC <= BUS;
                    PC_ADDER: PC <= adder_out;
                    PC_INC:   PC <= PC + WIDTH'(1);
                    PC_HOLD:  PC <= PC;
                    default:  PC <= PC;
                endcase
            end
            if (LD[LD_CC]) NZP <= cc_of(BUS);
            // Uses the condition codes held before this edge.
            if (LD[LD_BEN]) BEN <= |(IR[11:9] & NZP);
        end
    end

endmodule

// File: tb/tb_lc3_datapath_p.sv
// Scoreboard bench for lc3_datapath_p: stimulus queues expected values, a
// negedge monitor compares them when probed or when a memory event appears.
module tb_lc3_datapath_p;

    localparam int S_BUS = 0, S_CONF = 1, S_PC = 2, S_NZP = 3, S_BEN = 4, S_MDR = 5;
    localparam int S_BUSY = 6, S_REQ = 7, S_DONE = 8, S_TO = 9, S_IR = 10, S_MAR = 11;
    localparam int S_BUS32 = 12, S_ADDR = 13, S_WDATA = 14;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        string       name;
        int          busy;
        logic [31:0] mdr;
    } ev_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  GATE;
    logic [6:0]  LD;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX;
    logic        MEM_START, MEM_WE, MEM_ACK;
    logic [31:0] rdata32;
    logic [15:0] rdata16;

    logic [15:0] MAR, MDR, IR, PC, BUS, MEM_ADDR, MEM_WDATA;
    logic        MEM_REQ, MEM_BUSY, MEM_DONE, MEM_TIMEOUT, BEN, BUS_CONFLICT;
    logic [2:0]  NZP;

    logic [31:0] MAR32, MDR32, IR32, PC32, BUS32, MEM_ADDR32, MEM_WDATA32;
    logic        MEM_REQ32, MEM_BUSY32, MEM_DONE32, MEM_TIMEOUT32, BEN32, BUS_CONFLICT32;
    logic [2:0]  NZP32;

    chk_t chk_q[$];
    ev_t  done_q[$];
    ev_t  to_q[$];
    logic probe;
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    logic to_prev = 1'b0;

    assign rdata16 = rdata32[15:0];

    always #5 Clk = ~Clk;

    lc3_datapath_p #(.WIDTH(16), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .GATE(GATE), .LD(LD), .PCMUX(PCMUX),
        .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .ALUK(ALUK), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MEM_START(MEM_START), .MEM_WE(MEM_WE),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(rdata16), .MAR(MAR), .MDR(MDR), .IR(IR),
        .PC(PC), .BUS(BUS), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE),
        .MEM_TIMEOUT(MEM_TIMEOUT), .BEN(BEN), .BUS_CONFLICT(BUS_CONFLICT), .NZP(NZP)
    );

    lc3_datapath_p #(.WIDTH(32), .TIMEOUT(15)) dut32 (
        .Clk(Clk), .Reset(Reset), .GATE(GATE), .LD(LD), .PCMUX(PCMUX),
        .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .ALUK(ALUK), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MEM_START(MEM_START), .MEM_WE(MEM_WE),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(rdata32), .MAR(MAR32), .MDR(MDR32), .IR(IR32),
        .PC(PC32), .BUS(BUS32), .MEM_REQ(MEM_REQ32), .MEM_ADDR(MEM_ADDR32),
        .MEM_WDATA(MEM_WDATA32), .MEM_BUSY(MEM_BUSY32), .MEM_DONE(MEM_DONE32),
        .MEM_TIMEOUT(MEM_TIMEOUT32), .BEN(BEN32), .BUS_CONFLICT(BUS_CONFLICT32), .NZP(NZP32)
    );

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_BUS:   return {16'h0, BUS};
            S_CONF:  return 32'(BUS_CONFLICT);
            S_PC:    return {16'h0, PC};
            S_NZP:   return 32'(NZP);
            S_BEN:   return 32'(BEN);
            S_MDR:   return {16'h0, MDR};
            S_BUSY:  return 32'(MEM_BUSY);
            S_REQ:   return 32'(MEM_REQ);
            S_DONE:  return 32'(MEM_DONE);
            S_TO:    return 32'(MEM_TIMEOUT);
            S_IR:    return {16'h0, IR};
            S_MAR:   return {16'h0, MAR};
            S_BUS32: return BUS32;
            S_ADDR:  return {16'h0, MEM_ADDR};
            S_WDATA: return {16'h0, MEM_WDATA};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: probed checks plus memory completion / timeout events.
    always @(negedge Clk) begin
        if (!Reset) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
            to_prev   = 1'b0;
        end else begin
            if (done_prev) cmp("done_pulse_width", 32'(MEM_DONE), 32'd0);
            if (to_prev) cmp("timeout_pulse_width", 32'(MEM_TIMEOUT), 32'd0);
            done_prev = MEM_DONE;
            to_prev   = MEM_TIMEOUT;
            if (MEM_BUSY) busy_cnt++;
            if (MEM_DONE) begin
                cmp("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    ev_t e;
                    e = done_q.pop_front();
                    cmp({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
                    cmp({e.name, "_mdr"}, {16'h0, MDR}, e.mdr);
                end
                busy_cnt = 0;
            end
            if (MEM_TIMEOUT) begin
                cmp("timeout_expected", 32'(to_q.size() != 0), 32'd1);
                if (to_q.size() != 0) begin
                    ev_t e;
                    e = to_q.pop_front();
                    cmp({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
                    cmp({e.name, "_mdr"}, {16'h0, MDR}, e.mdr);
                end
                busy_cnt = 0;
            end
        end
        if (probe) begin
            while (chk_q.size() != 0) begin
                chk_t c;
                c = chk_q.pop_front();
                cmp(c.name, sig_val(c.sig), c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic want(input string name, input int s, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sig  = s;
        c.exp  = v;
        chk_q.push_back(c);
        probe = 1'b1;
    endtask

    task automatic mem_txn(input string name, input logic we, input logic [31:0] v,
                           input int ack_delay, input logic ld5, input logic [31:0] exp_mdr);
        ev_t e;
        e.name = name;
        e.busy = ack_delay + 1;
        e.mdr  = exp_mdr;
        done_q.push_back(e);
        MEM_WE    = we;
        MEM_START = 1'b1;
        tick();
        MEM_START = 1'b0;
        repeat (ack_delay) tick();
        MEM_ACK = 1'b1;
        rdata32 = v;
        if (ld5) begin
            LD   = 7'b0100000;
            GATE = 4'b0100;
        end
        tick();
        MEM_ACK = 1'b0;
        LD      = '0;
        GATE    = '0;
        tick();
    endtask

    // Copy MDR onto the bus and load it into the selected registers.
    task automatic mdr_to(input logic [6:0] ld);
        GATE = 4'b1000;
        LD   = ld;
        tick();
        GATE = '0;
        LD   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t te;
        Reset = 1'b0; GATE = '0; LD = '0; PCMUX = '0; ADDR2MUX = '0; ADDR1MUX = 1'b0;
        ALUK = '0; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        MEM_START = 1'b0; MEM_WE = 1'b0; MEM_ACK = 1'b0; rdata32 = '0; probe = 1'b0;
        tick();
        tick();
        want("rst_pc", S_PC, 0);     want("rst_mdr", S_MDR, 0);
        want("rst_ir", S_IR, 0);     want("rst_mar", S_MAR, 0);
        want("rst_nzp", S_NZP, 3'b010); want("rst_ben", S_BEN, 0);
        want("rst_req", S_REQ, 0);   want("rst_busy", S_BUSY, 0);
        want("rst_done", S_DONE, 0); want("rst_timeout", S_TO, 0);
        want("rst_bus", S_BUS, 0);   want("rst_conflict", S_CONF, 0);
        tick();
        Reset = 1'b1;
        tick();

        // Reset in the middle of a read aborts it without touching MDR.
        MEM_START = 1'b1;
        tick();
        MEM_START = 1'b0;
        tick();
        tick();
        want("midreq_busy", S_BUSY, 1);
        want("midreq_req", S_REQ, 1);
        tick();
        Reset = 1'b0; MEM_ACK = 1'b1; rdata32 = 32'h1234;
        want("abort_busy", S_BUSY, 0); want("abort_pc", S_PC, 0);
        want("abort_nzp", S_NZP, 3'b010); want("abort_mdr", S_MDR, 0);
        tick();
        Reset = 1'b1; MEM_ACK = 1'b0;
        tick();
        want("post_abort_mdr", S_MDR, 0); want("post_abort_busy", S_BUSY, 0);
        want("post_abort_done", S_DONE, 0);
        tick();

        // PC wrap and bus arbitration.
        mem_txn("rd_ffff", 1'b0, 32'hFFFF, 0, 1'b0, 32'hFFFF);
        GATE = 4'b1000; LD = 7'b0001000; PCMUX = 2'd0;
        want("bus_mdr", S_BUS, 16'hFFFF);
        tick();
        GATE = '0; LD = '0;
        want("pc_ffff", S_PC, 16'hFFFF);
        LD = 7'b0001000; PCMUX = 2'd2;
        tick();
        LD = '0;
        want("pc_wrap", S_PC, 0); want("bus_none", S_BUS, 0); want("conflict_none", S_CONF, 0);
        tick();
        GATE = 4'b0110;
        want("bus_0110", S_BUS, 0); want("conflict_0110", S_CONF, 1);
        tick();
        GATE = 4'b1001;
        want("bus_1001", S_BUS, 0); want("conflict_1001", S_CONF, 1);
        tick();
        GATE = '0;

        // Condition codes and branch enable.
        mem_txn("rd_0005", 1'b0, 32'h0005, 0, 1'b0, 32'h0005);
        mdr_to(7'b0000010);
        want("nzp_pos", S_NZP, 3'b001);
        LD = 7'b0000010;
        tick();
        LD = '0;
        want("nzp_zero", S_NZP, 3'b010);
        mem_txn("rd_8000", 1'b0, 32'h8000, 0, 1'b0, 32'h8000);
        mdr_to(7'b0000010);
        want("nzp_neg", S_NZP, 3'b100);
        mem_txn("rd_0800", 1'b0, 32'h0800, 0, 1'b0, 32'h0800);
        mdr_to(7'b0010000);
        LD = 7'b0000100;
        tick();
        LD = '0;
        want("ben_100", S_BEN, 1);
        mem_txn("rd_0600", 1'b0, 32'h0600, 0, 1'b0, 32'h0600);
        mdr_to(7'b0010000);
        LD = 7'b0000100;
        tick();
        LD = '0;
        want("ben_011", S_BEN, 0);
        mem_txn("rd_0800b", 1'b0, 32'h0800, 0, 1'b0, 32'h0800);
        mdr_to(7'b0010000);
        want("nzp_before", S_NZP, 3'b100);
        LD = 7'b0000110;
        tick();
        LD = '0;
        want("ben_old_nzp", S_BEN, 1); want("nzp_after", S_NZP, 3'b010);

        // Memory handshake: ACK after 3 wait cycles, read beats LD[5].
        mem_txn("rd_beef", 1'b0, 32'hBEEF, 3, 1'b1, 32'hBEEF);
        mdr_to(7'b1000000);
        want("mem_addr", S_ADDR, 16'hBEEF); want("mem_wdata", S_WDATA, 16'hBEEF);
        want("mar", S_MAR, 16'hBEEF);
        tick();

        te.name = "timeout15"; te.busy = 15; te.mdr = 32'hBEEF;
        to_q.push_back(te);
        MEM_WE = 1'b0; MEM_START = 1'b1;
        tick();
        MEM_START = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            MEM_START = (i == 5);
            tick();
        end
        MEM_START = 1'b0;
        tick();
        mem_txn("ack_on_15", 1'b0, 32'hCAFE, 14, 1'b0, 32'hCAFE);

        MEM_ACK = 1'b1; rdata32 = 32'h1111;
        tick();
        MEM_ACK = 1'b0;
        want("stray_ack_mdr", S_MDR, 16'hCAFE); want("stray_ack_done", S_DONE, 0);
        want("stray_ack_busy", S_BUSY, 0);
        tick();
        mem_txn("wr_5555", 1'b1, 32'h5555, 1, 1'b0, 32'hCAFE);
        MEM_WE = 1'b0;

        // Register file, ALU and address adder with IR = 0x0E3F (DR/SR1 = R7).
        mem_txn("rd_0e3f", 1'b0, 32'h0E3F, 0, 1'b0, 32'h0E3F);
        mdr_to(7'b0010000);
        mem_txn("rd_1234", 1'b0, 32'h1234, 0, 1'b0, 32'h1234);
        mdr_to(7'b0000001);
        GATE = 4'b0001; SR1MUX = 1'b0; SR2MUX = 1'b1; ALUK = 2'd0;
        want("alu_add_imm", S_BUS, 16'h1233);
        tick();
        ALUK = 2'd1;
        want("alu_and_imm", S_BUS, 16'h1234);
        tick();
        ALUK = 2'd2;
        want("alu_not", S_BUS, 16'hEDCB);
        tick();
        SR2MUX = 1'b0; ALUK = 2'd0; LD = 7'b0000001;
        want("alu_add_reg", S_BUS, 16'h2468);
        tick();
        LD = '0; ALUK = 2'd3;
        want("r7_written", S_BUS, 16'h2468);
        tick();
        SR1MUX = 1'b1; ALUK = 2'd2;
        want("not_r0", S_BUS, 16'hFFFF);
        tick();
        SR1MUX = 1'b0;
        GATE = 4'b0010; ADDR1MUX = 1'b0; ADDR2MUX = 2'd2;
        want("adder_off6", S_BUS, 16'h2467);
        tick();
        ADDR2MUX = 2'd0;
        want("adder_off11", S_BUS, 16'h22A7);
        tick();
        ADDR2MUX = 2'd3; LD = 7'b0001000; PCMUX = 2'd1;
        want("adder_zero", S_BUS, 16'h2468);
        tick();
        GATE = '0; LD = 7'b0001000; PCMUX = 2'd3;
        want("pc_from_adder", S_PC, 16'h2468);
        tick();
        GATE = 4'b0100; LD = 7'b0100000;
        want("pc_hold", S_PC, 16'h2468);
        tick();
        GATE = '0; LD = '0;
        want("mdr_from_bus", S_MDR, 16'h2468);
        tick();

        // PC-relative address with a negative 9-bit offset, both widths.
        mem_txn("rd_01ff", 1'b0, 32'h01FF, 0, 1'b0, 32'h01FF);
        mdr_to(7'b0010000);
        mem_txn("rd_0100", 1'b0, 32'h0100, 0, 1'b0, 32'h0100);
        PCMUX = 2'd0;
        mdr_to(7'b0001000);
        GATE = 4'b0010; ADDR1MUX = 1'b1; ADDR2MUX = 2'd1;
        want("pcrel_16", S_BUS, 16'h00FF);
        want("pcrel_32", S_BUS32, 32'h0000_00FF);
        tick();
        GATE = '0;
        tick();
        tick();

        cmp("done_q_drained", 32'(done_q.size()), 32'd0);
        cmp("timeout_q_drained", 32'(to_q.size()), 32'd0);
        cmp("chk_q_drained", 32'(chk_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
